carry_lookahead_adder_unit: RTL and testbench

- Registered N-bit binary adder built from a two-level carry-lookahead network.
- Computes {cout, s} = a + b + cin and captures the result in output registers one clock after the operands are sampled.
- Serves as the shared integer add datapath for ALU and address-generation logic.
- Internally tiles NBIT into BLOCK-bit lookahead blocks whose group generate/propagate signals feed a second-level carry unit.

---
 rtl/cla_pkg.sv | 16 +
 rtl/cla_block.sv | 68 ++++++
 rtl/carry_lookahead_adder_unit.sv | 107 ++++++++++
 tb/tb_carry_lookahead_adder_unit.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared definitions for the carry-lookahead adder unit.
//   CLA_NBIT  : default operand/sum width
//   CLA_BLOCK : default width of one first-level lookahead block
//   gp_t      : group generate/propagate pair passed from the blocks to the
//               second-level carry unit
package cla_pkg;

    localparam int CLA_NBIT  = 32;
    localparam int CLA_BLOCK = 4;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

endpackage : cla_pkg

// File: rtl/cla_block.sv
// Combinational BLOCK-bit carry-lookahead adder slice.
// Ports:
//   a, b   [BLOCK-1:0] in  : operand slices
//   cin            in  : carry into the slice
//   s      [BLOCK-1:0] out : sum slice
//   g_grp          out : group generate (slice generates a carry by itself)
//   p_grp          out : group propagate (slice passes cin straight through)
//   cout           out : carry out of the slice
module cla_block
    import cla_pkg::*;
#(
    parameter int BLOCK = CLA_BLOCK
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             cin,
    output logic [BLOCK-1:0] s,
    output logic             g_grp,
    output logic             p_grp,
    output logic             cout
);

    logic [BLOCK-1:0] g_s;
    logic [BLOCK-1:0] p_s;
    logic [BLOCK-1:0] gen_s;   // generate of bits [k:0] taken as one group
    logic [BLOCK-1:0] prop_s;  // propagate of bits [k:0] taken as one group
    logic [BLOCK:0]   c_s;

    assign g_s = a & b;
    assign p_s = a ^ b;

    // Prefix generate/propagate for every bit position, each built as an
    // independent sum of products over g/p so no carry depends on another.
    always_comb begin
        logic sop_s;
        logic run_s;
        gen_s  = '0;
        prop_s = '0;
        sop_s  = 1'b0;
        run_s  = 1'b1;
        for (int k = 0; k < BLOCK; k++) begin
            sop_s = 1'b0;
            run_s = 1'b1;
            // term j: g[j] & p[j+1] & ... & p[k]
            for (int j = k; j >= 0; j--) begin
                sop_s = sop_s | (g_s[j] & run_s);
                run_s = run_s & p_s[j];
            end
            gen_s[k]  = sop_s;
            prop_s[k] = run_s;
        end
    end

    // Internal carries from the prefix terms and the slice carry-in.
    always_comb begin
        c_s    = '0;
        c_s[0] = cin;
        for (int k = 0; k < BLOCK; k++) begin
            c_s[k+1] = gen_s[k] | (prop_s[k] & cin);
        end
    end

    assign s     = p_s ^ c_s[BLOCK-1:0];
    assign g_grp = gen_s[BLOCK-1];
    assign p_grp = prop_s[BLOCK-1];
    assign cout  = c_s[BLOCK];

endmodule : cla_block

// File: rtl/carry_lookahead_adder_unit.sv
// Registered NBIT-bit two-level carry-lookahead adder: {cout, s} = a + b + cin,
// captured one clock after in_valid.
// Ports:
//   clk, rst_n          in  : clock, asynchronous active-low reset
//   in_valid            in  : a/b/cin are valid this cycle
//   a, b    [NBIT-1:0]  in  : unsigned operands
//   cin                 in  : carry into bit 0
//   out_valid           out : s/cout hold the result of an accepted operation
//   s       [NBIT-1:0]  out : registered sum
//   cout                out : registered carry out of bit NBIT-1
module carry_lookahead_adder_unit
    import cla_pkg::*;
#(
    parameter int NBIT  = CLA_NBIT,
    parameter int BLOCK = CLA_BLOCK
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [NBIT-1:0] a,
    input  logic [NBIT-1:0] b,
    input  logic            cin,
    output logic            out_valid,
    output logic [NBIT-1:0] s,
    output logic            cout
);

    localparam int NBLK = NBIT / BLOCK;

    if ((BLOCK < 1) || (NBIT < BLOCK) || ((NBIT % BLOCK) != 0)) begin : g_bad_cfg
        $error("carry_lookahead_adder_unit: NBIT must be a positive multiple of BLOCK");
    end

    gp_t [NBLK-1:0] gp_s;
    logic [NBLK:0]   cblk_s;   // carry into each block; top entry is the adder carry-out
    logic [NBIT-1:0] sum_s;
    logic [NBLK-1:0] bcout_s;
    logic            unused_bcout_s;

    logic [NBIT-1:0] s_r;
    logic            cout_r;
    logic            out_valid_r;

    for (genvar m = 0; m < NBLK; m++) begin : g_blk
        logic g_b;
        logic p_b;

        cla_block #(
            .BLOCK (BLOCK)
        ) u_blk (
            .a     (a[m*BLOCK +: BLOCK]),
            .b     (b[m*BLOCK +: BLOCK]),
            .cin   (cblk_s[m]),
            .s     (sum_s[m*BLOCK +: BLOCK]),
            .g_grp (g_b),
            .p_grp (p_b),
            .cout  (bcout_s[m])
        );

        assign gp_s[m] = '{g: g_b, p: p_b};
    end

    // The lookahead network below already yields every block carry-out,
    // so the per-block ripple outputs are intentionally left unused.
    assign unused_bcout_s = ^bcout_s;

    // Second-level lookahead: each block carry-in is a flat sum of products
    // over the group G/P of all lower blocks and cin.
    always_comb begin
        logic sop_s;
        logic run_s;
        cblk_s    = '0;
        cblk_s[0] = cin;
        sop_s     = 1'b0;
        run_s     = 1'b1;
        for (int m = 1; m <= NBLK; m++) begin
            sop_s = 1'b0;
            run_s = 1'b1;
            for (int j = m - 1; j >= 0; j--) begin
                sop_s = sop_s | (gp_s[j].g & run_s);
                run_s = run_s & gp_s[j].p;
            end
            cblk_s[m] = sop_s | (run_s & cin);
        end
    end

    // Output registers: load on accepted operation, otherwise hold the result
    // and drop out_valid; reset clears everything, discarding any in-flight op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_r         <= '0;
            cout_r      <= 1'b0;
            out_valid_r <= 1'b0;
        end else if (in_valid) begin
            s_r         <= sum_s;
            cout_r      <= cblk_s[NBLK];
            out_valid_r <= 1'b1;
        end else begin
            out_valid_r <= 1'b0;
        end
    end

    assign s         = s_r;
    assign cout      = cout_r;
    assign out_valid = out_valid_r;

endmodule : carry_lookahead_adder_unit

// File: tb/tb_carry_lookahead_adder_unit.sv
// Scoreboard bench for carry_lookahead_adder_unit: a 32-bit instance and a
// single-block 4-bit instance; expected results queued at issue, checked by
// a monitor whenever out_valid is high.
module tb_carry_lookahead_adder_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        out_valid;
    logic [31:0] s;
    logic        cout;

    logic        in_valid4;
    logic [3:0]  a4;
    logic [3:0]  b4;
    logic        cin4;
    logic        out_valid4;
    logic [3:0]  s4;
    logic        cout4;

    int tests = 0;
    int fails = 0;

    logic [32:0] exp32_q[$];
    logic [4:0]  exp4_q[$];
    logic [32:0] last32;
    logic [4:0]  last4;

    always #5 clk = ~clk;

    carry_lookahead_adder_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .s         (s),
        .cout      (cout)
    );

    carry_lookahead_adder_unit #(
        .NBIT  (4),
        .BLOCK (4)
    ) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid4),
        .a         (a4),
        .b         (b4),
        .cin       (cin4),
        .out_valid (out_valid4),
        .s         (s4),
        .cout      (cout4)
    );

    function automatic logic [32:0] add33(input logic [31:0] x, input logic [31:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + {32'b0, c};
    endfunction

    function automatic logic [4:0] add5(input logic [3:0] x, input logic [3:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + {4'b0, c};
    endfunction

    task automatic check(input string name, input logic [32:0] got, input logic [32:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Monitor: every presented result must match the oldest queued expectation.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (exp32_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected32: got %h with out_valid=1, expected no result", {cout, s});
            end else begin
                check("sum32", {cout, s}, exp32_q.pop_front());
            end
        end
        if (out_valid4 === 1'b1) begin
            if (exp4_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected4: got %h with out_valid=1, expected no result", {cout4, s4});
            end else begin
                check("sum4", {28'b0, cout4, s4}, {28'b0, exp4_q.pop_front()});
            end
        end
    end

    // Called on a falling edge; returns on the next falling edge.
    task automatic drive32(input logic [31:0] x, input logic [31:0] y, input logic c, input logic [32:0] e);
        a        = x;
        b        = y;
        cin      = c;
        in_valid = 1'b1;
        exp32_q.push_back(e);
        last32 = e;
        @(negedge clk);
    endtask

    task automatic drive4(input logic [3:0] x, input logic [3:0] y, input logic c, input logic [4:0] e);
        a4        = x;
        b4        = y;
        cin4      = c;
        in_valid4 = 1'b1;
        exp4_q.push_back(e);
        last4 = e;
        @(negedge clk);
    endtask

    task automatic idle32(input string name);
        in_valid = 1'b0;
        @(negedge clk);
        check({name, "_valid"}, {32'b0, out_valid}, 33'h0);
        check({name, "_hold"}, {cout, s}, last32);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rc;
        logic [8:0]  v;

        rst_n     = 1'b0;
        in_valid  = 1'b1;
        a         = 32'd5;
        b         = 32'd7;
        cin       = 1'b0;
        in_valid4 = 1'b0;
        a4        = 4'd0;
        b4        = 4'd0;
        cin4      = 1'b0;
        last32    = 33'h0;
        last4     = 5'h0;

        // Reset held across clock edges while inputs are valid
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("rst_valid", {32'b0, out_valid}, 33'h0);
        check("rst_sum", {cout, s}, 33'h0);
        check("rst_valid4", {32'b0, out_valid4}, 33'h0);
        check("rst_sum4", {28'b0, cout4, s4}, 33'h0);

        rst_n = 1'b1;
        drive32(32'd5, 32'd7, 1'b0, 33'd12);

        // Carry propagation and maximum-operand boundaries
        drive32(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 33'h1_0000_0000);
        drive32(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 33'h0_8000_0000);
        drive32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 33'h1_FFFF_FFFF);
        drive32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 33'h1_FFFF_FFFE);
        drive32(32'h0000_000F, 32'h0000_0001, 1'b0, 33'h0_0000_0010);
        drive32(32'h00FF_FFFF, 32'h0000_0000, 1'b1, 33'h0_0100_0000);
        drive32(32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 33'h1_0000_0000);
        drive32(32'h1234_5678, 32'h8765_4321, 1'b0, 33'h0_9999_9999);
        idle32("idle_a");

        // Back-to-back throughput then one idle cycle
        for (int i = 0; i < 16; i++) begin
            ra = $urandom();
            rb = $urandom();
            rc = 1'($urandom_range(0, 1));
            drive32(ra, rb, rc, add33(ra, rb, rc));
        end
        idle32("idle_b");

        // Single-block instance: exhaustive, then spot check and hold
        for (int i = 0; i < 512; i++) begin
            v = 9'(i);
            drive4(v[8:5], v[4:1], v[0], add5(v[8:5], v[4:1], v[0]));
        end
        drive4(4'd9, 4'd8, 1'b1, 5'h12);
        in_valid4 = 1'b0;
        @(negedge clk);
        check("idle4_valid", {32'b0, out_valid4}, 33'h0);
        check("idle4_hold", {28'b0, cout4, s4}, {28'b0, last4});

        // Reset asserted between edges during a back-to-back run
        for (int i = 0; i < 3; i++) begin
            ra = $urandom();
            rb = $urandom();
            drive32(ra, rb, 1'b0, add33(ra, rb, 1'b0));
        end
        a        = 32'h1234_5678;
        b        = 32'h0FED_CBA9;
        cin      = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        check("pre_rst_valid", {32'b0, out_valid}, 33'h1);
        check("pre_rst_sum", {cout, s}, 33'h0_2222_2222);
        #1;
        rst_n = 1'b0;
        exp32_q.delete();
        a = 32'hDEAD_BEEF;
        b = 32'h0000_1111;
        #1;
        check("async_clr_valid", {32'b0, out_valid}, 33'h0);
        check("async_clr_sum", {cout, s}, 33'h0);
        check("async_clr_sum4", {28'b0, cout4, s4}, 33'h0);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_valid", {32'b0, out_valid}, 33'h0);
            check("post_rst_sum", {cout, s}, 33'h0);
        end

        check("drain32", 33'(exp32_q.size()), 33'h0);
        check("drain4", 33'(exp4_q.size()), 33'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_carry_lookahead_adder_unit
